wb_commit_stage: RTL and testbench
==================================

// Module: wb_commit_stage
// PURPOSE
//  Write-back/commit stage of the LoongArch pipeline; directly upstream of the CSR file.
//  Latches the MEM-stage bus and resolves the exception, interrupt and ERTN commit.
//  Drives the CSR file's write/ex/eret inputs, the regfile write port and the debug trace.
//  Issues a registered front-end redirect and a same-cycle pipeline flush.
// PARAMETERS
//  CNT_W     32   width of retired-instruction counter (16..64)
//  ECODE_INT 6'h0 ecode reported for interrupts
// PORTS
//  clk            in   1   clock, all state on posedge
//  resetn         in   1   asynchronous active-low reset
//  ms_to_ws_valid in   1   MEM stage holds a valid instr
//  ms_pc          in   32  instr PC
//  ms_ex          in   1   instr carries sync exception
//  ms_ecode       in   6   / ms_esubcode in 9: exception codes
//  ms_ertn        in   1   instr is ERTN
//  ms_csr_we      in   1   / ms_csr_num 14 / ms_csr_wmask 32 / ms_csr_wvalue 32: CSR write
//  ms_rf_we       in   1   / ms_rf_waddr 5 / ms_rf_wdata 32: GPR write
//  has_int        in   1   CSR file reports enabled pending interrupt
//  csr_eentry     in   32  / csr_era in 32: redirect targets from CSR file
//  ws_allowin     out  1   stage can accept
//  csr_we,csr_num,csr_wmask,csr_wvalue out 1/14/32/32  to CSR file
//  wb_ex,wb_ecode,wb_esubcode,eret_flush,wb_pc out 1/6/9/1/32  to CSR file
//  ws_flush       out  1   kill all younger instrs (comb)
//  redirect_valid out  1   / redirect_pc out 32: registered front-end redirect
//  rf_we,rf_waddr,rf_wdata out 1/5/32  GPR port
//  debug_wb_pc,debug_wb_rf_we[3:0],debug_wb_rf_wnum,debug_wb_rf_wdata out  trace
//  instret        out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Pipeline reg: ws_valid <= ms_to_ws_valid & ws_allowin & ~ws_flush; payload latched when
//    ms_to_ws_valid & ws_allowin. ws_ready_go=1; ws_allowin = 1 always (single-cycle commit).
//  - take_int = ws_valid & has_int (macro-gated); ex_go = ws_valid & (ms-latched ex | take_int).
//  - Priority: interrupt > sync ex > ERTN > normal. Interrupt on ERTN/excepting instr -> INT.
//  - wb_ex = ex_go; wb_ecode = take_int ? ECODE_INT : latched ecode; wb_esubcode 0 on INT.
//  - eret_flush = ws_valid & ertn & ~ex_go. wb_pc = latched PC.
//  - ws_flush = wb_ex | eret_flush; in that cycle incoming MEM instr is dropped (ws_valid<=0).
//  - csr_we, rf_we = ws_valid & latched we & ~ex_go (suppressed on ex/INT; ERTN has none).
//  - Redirect: next cycle redirect_valid=1 for exactly one cycle,
//    redirect_pc = wb_ex ? csr_eentry : csr_era, sampled in the commit cycle.
//  - Back-to-back: a ws_flush in cycle N guarantees no ws_valid in N+1; no double redirect.
//  - instret += 1 on ws_valid & ~ex_go (ERTN counts); wraps 2^CNT_W-1 -> 0 silently.
//  - debug_wb_rf_we = {4{rf_we}}; debug_wb_pc = ws_valid ? pc : 0.
//  - Reset (async, any cycle incl. mid-commit): ws_valid=0, redirect_valid=0, redirect_pc=0,
//    instret=0, payload regs 0 -> all outputs 0 except ws_allowin=1. Release sync to clk.
// CONFIGURATION
//  WB_COMMIT_INT_EN defined: has_int honoured as above.
//  Undefined: has_int ignored, take_int=0; ECODE_INT unused; port kept for pinout stability.
// TESTING
//  1 normal: pc=0x1c000000 rf_we waddr=5 wdata=0x1234 -> rf_we 1 cycle later, instret=1, no flush
//  2 sync ex: ms_ex ecode=0x0b(SYS) rf_we=1 -> wb_ex=1 ecode=0x0b, rf_we=0, ws_flush=1;
//    next cycle redirect_valid=1 redirect_pc=csr_eentry=0x1c008000, instret unchanged
//  3 ERTN, csr_era=0x1c000044 -> eret_flush=1, redirect_pc=0x1c000044 next cycle, instret+1
//  4 INT_EN, has_int=1 with ERTN in WB -> wb_ex=1 ecode=0, eret_flush=0, esubcode=0
//  5 flush drop: ms_to_ws_valid=1 in commit cycle of ex -> ws_valid=0 next cycle, no rf_we
//  6 resetn low mid-redirect -> redirect_valid,instret,ws_valid 0 immediately (async)

Source files
------------

// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: latches the MEM bus, resolves exception/interrupt/ERTN commit,
// drives CSR, regfile and trace ports. Interrupt acceptance is gated by `WB_COMMIT_INT_EN.
module wb_commit_stage #(
  parameter int         CNT_W     = 32,
  parameter logic [5:0] ECODE_INT = 6'h0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms_to_ws_valid,
  input  logic [31:0]      ms_pc,
  input  logic             ms_ex,
  input  logic [5:0]       ms_ecode,
  input  logic [8:0]       ms_esubcode,
  input  logic             ms_ertn,
  input  logic             ms_csr_we,
  input  logic [13:0]      ms_csr_num,
  input  logic [31:0]      ms_csr_wmask,
  input  logic [31:0]      ms_csr_wvalue,
  input  logic             ms_rf_we,
  input  logic [4:0]       ms_rf_waddr,
  input  logic [31:0]      ms_rf_wdata,
  input  logic             has_int,
  input  logic [31:0]      csr_eentry,
  input  logic [31:0]      csr_era,
  output logic             ws_allowin,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic             eret_flush,
  output logic [31:0]      wb_pc,
  output logic             ws_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] instret
);

  // Handshake: MEM offers an instr with ms_to_ws_valid; it is taken on any clock edge
  // where ws_allowin is high. Commit takes one cycle, so ws_allowin is constantly 1.
  logic        ws_valid;
  logic [31:0] pc_q;
  logic        ex_q;
  logic [5:0]  ecode_q;
  logic [8:0]  esubcode_q;
  logic        ertn_q;
  logic        csr_we_q;
  logic [13:0] csr_num_q;
  logic [31:0] csr_wmask_q;
  logic [31:0] csr_wvalue_q;
  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        take_int;
  logic        ex_go;
  logic        commit_ok;

`ifdef WB_COMMIT_INT_EN
  assign take_int = ws_valid & has_int;
`else
  logic unused_int;
  assign unused_int = has_int ^ (|ECODE_INT);
  assign take_int   = 1'b0;
`endif

  assign ws_allowin = 1'b1;
  assign ex_go      = ws_valid & (ex_q | take_int);
  assign commit_ok  = ws_valid & ~ex_go;

  assign wb_ex       = ex_go;
`ifdef WB_COMMIT_INT_EN
  assign wb_ecode    = take_int ? ECODE_INT : ecode_q;
  assign wb_esubcode = take_int ? 9'd0 : esubcode_q;
`else
  assign wb_ecode    = ecode_q;
  assign wb_esubcode = esubcode_q;
`endif
  assign eret_flush  = ws_valid & ertn_q & ~ex_go;
  assign wb_pc       = pc_q;
  assign ws_flush    = wb_ex | eret_flush;

  assign csr_we     = commit_ok & csr_we_q;
  assign csr_num    = csr_num_q;
  assign csr_wmask  = csr_wmask_q;
  assign csr_wvalue = csr_wvalue_q;

  assign rf_we    = commit_ok & rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  assign debug_wb_pc       = ws_valid ? pc_q : 32'd0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr_q;
  assign debug_wb_rf_wdata = rf_wdata_q;

  // The instr arriving during a flush cycle is younger than the flushing one, so drop it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid & ~ws_flush;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q         <= 32'd0;
      ex_q         <= 1'b0;
      ecode_q      <= 6'd0;
      esubcode_q   <= 9'd0;
      ertn_q       <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_num_q    <= 14'd0;
      csr_wmask_q  <= 32'd0;
      csr_wvalue_q <= 32'd0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      pc_q         <= ms_pc;
      ex_q         <= ms_ex;
      ecode_q      <= ms_ecode;
      esubcode_q   <= ms_esubcode;
      ertn_q       <= ms_ertn;
      csr_we_q     <= ms_csr_we;
      csr_num_q    <= ms_csr_num;
      csr_wmask_q  <= ms_csr_wmask;
      csr_wvalue_q <= ms_csr_wvalue;
      rf_we_q      <= ms_rf_we;
      rf_waddr_q   <= ms_rf_waddr;
      rf_wdata_q   <= ms_rf_wdata;
    end
  end

  // Target is sampled in the commit cycle; the CSR file updates ERA/ESTAT on that same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= ws_flush;
      if (ws_flush) begin
        redirect_pc <= wb_ex ? csr_eentry : csr_era;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      instret <= '0;
    end else if (commit_ok) begin
      instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: expected commit records and redirect targets are queued
// by the stimulus flow and popped by a negedge monitor whenever the DUT presents them.
module tb_wb_commit_stage;

  localparam int W = 125;
  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000044;

  logic        clk;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_ertn;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask;
  logic [31:0] ms_csr_wvalue;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        has_int;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        ws_allowin;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        eret_flush;
  logic [31:0] wb_pc;
  logic        ws_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic [31:0] instret;

  logic [W-1:0] exp_q[$];
  logic [31:0]  rd_q[$];
  int n_cmp;
  int n_err;
  int model_cnt;

  wb_commit_stage #(.CNT_W(32), .ECODE_INT(6'h0)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
    .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_ertn(ms_ertn),
    .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
    .ms_csr_wvalue(ms_csr_wvalue), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .has_int(has_int), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .ws_allowin(ws_allowin), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .eret_flush(eret_flush), .wb_pc(wb_pc), .ws_flush(ws_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .instret(instret)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(
    input logic [31:0] pc, input logic ex, input logic [5:0] ecode, input logic [8:0] esub,
    input logic eret, input logic flush, input logic rfwe, input logic [3:0] dbg_we,
    input logic [4:0] waddr, input logic [31:0] wdata, input logic cwe, input logic [31:0] cnt);
    return {pc, ex, ecode, esub, eret, flush, rfwe, dbg_we, waddr, wdata, cwe, cnt};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one instr to the stage for the current cycle.
  task automatic drive(input logic [31:0] pc, input logic ex, input logic [5:0] ecode,
                       input logic [8:0] esub, input logic ertn, input logic cwe,
                       input logic rfwe, input logic [4:0] waddr, input logic [31:0] wdata);
    ms_to_ws_valid = 1'b1;
    ms_pc          = pc;
    ms_ex          = ex;
    ms_ecode       = ecode;
    ms_esubcode    = esub;
    ms_ertn        = ertn;
    ms_csr_we      = cwe;
    ms_csr_num     = 14'h0006;
    ms_csr_wmask   = 32'hffff_ffff;
    ms_csr_wvalue  = 32'h0000_00a5;
    ms_rf_we       = rfwe;
    ms_rf_waddr    = waddr;
    ms_rf_wdata    = wdata;
  endtask

  task automatic idle();
    ms_to_ws_valid = 1'b0;
  endtask

  // Hand-computed expectation for one commit cycle.
  task automatic expect_commit(input logic [31:0] pc, input logic ex, input logic [5:0] ecode,
                               input logic [8:0] esub, input logic eret, input logic rfwe,
                               input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic cwe);
    exp_q.push_back(pack(pc, ex, ecode, esub, eret, ex | eret, rfwe, {4{rfwe}}, waddr, wdata,
                         cwe, model_cnt));
    if (ex) rd_q.push_back(EENTRY);
    else if (eret) rd_q.push_back(ERA);
    if (!ex) model_cnt++;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (resetn) begin
      if (debug_wb_pc != 32'd0) begin
        logic [W-1:0] act;
        act = pack(debug_wb_pc, wb_ex, wb_ecode, wb_esubcode, eret_flush, ws_flush, rf_we,
                   debug_wb_rf_we, rf_waddr, rf_wdata, csr_we, instret);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL commit: unexpected commit pc=%0h", debug_wb_pc);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL commit pc=%0h: got %0h expected %0h", debug_wb_pc, act, e);
          end
        end
      end
      if (redirect_valid) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL redirect: unexpected redirect pc=%0h", redirect_pc);
        end else begin
          logic [31:0] r;
          r = rd_q.pop_front();
          if (redirect_pc !== r) begin
            n_err++;
            $display("FAIL redirect_pc: got %0h expected %0h", redirect_pc, r);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_cnt = 0;
    resetn = 1'b0;
    has_int = 1'b0;
    csr_eentry = EENTRY;
    csr_era = ERA;
    drive(32'd0, 1'b0, 6'd0, 9'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle();
    #12;
    check("reset_allowin", 64'(ws_allowin), 64'd1);
    check("reset_instret", 64'(instret), 64'd0);
    check("reset_redirect", 64'({redirect_valid, redirect_pc}), 64'd0);
    check("reset_dbg_pc", 64'(debug_wb_pc), 64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // normal ALU write, then CSR write
    drive(32'h1c000000, 1'b0, 6'd0, 9'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234);
    expect_commit(32'h1c000000, 1'b0, 6'd0, 9'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b0);
    tick();
    drive(32'h1c000004, 1'b0, 6'd0, 9'd0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0);
    expect_commit(32'h1c000004, 1'b0, 6'd0, 9'd0, 1'b0, 1'b0, 5'd6, 32'h0, 1'b1);
    tick();
    idle();
    tick();

    // SYSCALL with rf_we set: write suppressed, redirect to eentry
    drive(32'h1c000008, 1'b1, 6'h0b, 9'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'hdead);
    expect_commit(32'h1c000008, 1'b1, 6'h0b, 9'd0, 1'b0, 1'b0, 5'd7, 32'hdead, 1'b0);
    tick();
    idle();
    tick();
    check("redirect_one_shot_ex", 64'(redirect_valid), 64'd1);
    tick();
    check("redirect_single_cycle", 64'(redirect_valid), 64'd0);

    // ERTN
    drive(32'h1c00000c, 1'b0, 6'd0, 9'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    expect_commit(32'h1c00000c, 1'b0, 6'd0, 9'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    idle();
    tick();
    tick();

    // ERTN with pending interrupt; latched ecode/esubcode are nonzero so INT override shows
    drive(32'h1c000010, 1'b0, 6'h3f, 9'h1ff, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
`ifdef WB_COMMIT_INT_EN
    expect_commit(32'h1c000010, 1'b1, 6'h00, 9'h000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
`else
    expect_commit(32'h1c000010, 1'b0, 6'h3f, 9'h1ff, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
`endif
    tick();
    has_int = 1'b1;
    idle();
    tick();
    has_int = 1'b0;
    tick();

    // exception with a younger instr arriving in the commit cycle: must be dropped
    drive(32'h1c000014, 1'b1, 6'h08, 9'h001, 1'b0, 1'b0, 1'b0, 5'd1, 32'h11);
    expect_commit(32'h1c000014, 1'b1, 6'h08, 9'h001, 1'b0, 1'b0, 5'd1, 32'h11, 1'b0);
    tick();
    drive(32'h1c000018, 1'b0, 6'd0, 9'd0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
    tick();
    idle();
    check("drop_rf_we", 64'(rf_we), 64'd0);
    check("drop_csr_we", 64'(csr_we), 64'd0);
    check("drop_no_flush", 64'(ws_flush), 64'd0);
    tick();

    // pipeline resumes
    drive(32'h1c00001c, 1'b0, 6'd0, 9'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55);
    expect_commit(32'h1c00001c, 1'b0, 6'd0, 9'd0, 1'b0, 1'b1, 5'd3, 32'h55, 1'b0);
    tick();
    idle();
    tick();
    check("instret_total", 64'(instret), 64'(model_cnt));

    // async reset while redirect is pending
    drive(32'h1c000020, 1'b1, 6'h0b, 9'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    expect_commit(32'h1c000020, 1'b1, 6'h0b, 9'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    void'(rd_q.pop_back());
    tick();
    idle();
    tick();
    check("pre_reset_redirect", 64'(redirect_valid), 64'd1);
    resetn = 1'b0;
    #1;
    check("async_redirect_valid", 64'(redirect_valid), 64'd0);
    check("async_redirect_pc", 64'(redirect_pc), 64'd0);
    check("async_instret", 64'(instret), 64'd0);
    check("async_wb_pc", 64'(wb_pc), 64'd0);
    check("async_allowin", 64'(ws_allowin), 64'd1);
    model_cnt = 0;
    tick();
    resetn = 1'b1;
    tick();

    drive(32'h1c000024, 1'b0, 6'd0, 9'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h77);
    expect_commit(32'h1c000024, 1'b0, 6'd0, 9'd0, 1'b0, 1'b1, 5'd4, 32'h77, 1'b0);
    tick();
    idle();
    tick();
    tick();

    check("commit_queue_drained", 64'(exp_q.size()), 64'd0);
    check("redirect_queue_drained", 64'(rd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
